adpll_lock_monitor: RTL and testbench

//  Independent lock checker for the ADPLL output. Runs in the OUT_CLK (DCO) domain,

---
 rtl/adpll_lock_monitor.sv | 166 ++++++++++++++++
 tb/tb_adpll_lock_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_lock_monitor.sv
// Independent ADPLL lock checker: counts DCO cycles per REF period in the DCO domain
// and qualifies lock, frequency error and reference loss against the selected ratio.
module adpll_lock_monitor #(
  parameter int unsigned CW       = 12,
  parameter int unsigned BASE_MUL = 8,
  parameter int unsigned TOL      = 1,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MISS_CNT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ref_in,
  input  logic          M2,
  input  logic          M1,
  input  logic          M0,
  output logic          lock,
  output logic          meas_valid,
  output logic [CW-1:0] meas_count,
  output logic [CW:0]   freq_err,
  output logic          ref_lost
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(MISS_CNT + 1);
  localparam int unsigned RW = 3;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic          ref_meta;
  logic          ref_s;
  logic          ref_d;
  logic          rise;
  logic [CW-1:0] cnt;
  logic [RW-1:0] m_reg;
  logic          m_chg;
  logic [CW-1:0] target;
  logic [CW:0]   err_next;
  logic [CW:0]   err_mag;
  logic          win_good;
  logic          cnt_sat;
  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;

  // REF_CLK is asynchronous: two-flop synchronizer plus a delay flop for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_meta <= 1'b0;
      ref_s    <= 1'b0;
      ref_d    <= 1'b0;
    end else begin
      ref_meta <= ref_in;
      ref_s    <= ref_meta;
      ref_d    <= ref_s;
    end
  end

  assign rise = ref_s & ~ref_d;

  // Ratio select is quasi-static; any change restarts acquisition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reg <= '0;
    end else begin
      m_reg <= {M2, M1, M0};
    end
  end

  assign m_chg  = ({M2, M1, M0} != m_reg);
  assign target = CW'(BASE_MUL * (32'(m_reg) + 32'd1));

  // Window length counter; saturation doubles as the reference-loss timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CW'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign cnt_sat  = (cnt == CNT_MAX);
  assign err_next = {1'b0, cnt} - {1'b0, target};
  assign err_mag  = err_next[CW] ? (CW + 1)'(-err_next) : err_next;
  assign win_good = (err_mag <= (CW + 1)'(TOL));

  // Lock qualification FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      lock       <= 1'b0;
      meas_valid <= 1'b0;
      meas_count <= '0;
      freq_err   <= '0;
      ref_lost   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (m_chg) begin
        state    <= IDLE;
        lock     <= 1'b0;
        good_cnt <= '0;
        miss_cnt <= '0;
      end else if (state != IDLE && cnt_sat) begin
        state    <= IDLE;
        lock     <= 1'b0;
        ref_lost <= 1'b1;
        good_cnt <= '0;
        miss_cnt <= '0;
      end else if (rise) begin
        case (state)
          IDLE: begin
            state    <= ACQ;
            good_cnt <= '0;
            miss_cnt <= '0;
            ref_lost <= 1'b0;
          end
          ACQ: begin
            meas_valid <= 1'b1;
            meas_count <= cnt;
            freq_err   <= err_next;
            if (!win_good) begin
              good_cnt <= '0;
            end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
              state    <= LOCKED;
              lock     <= 1'b1;
              good_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end
          LOCKED: begin
            meas_valid <= 1'b1;
            meas_count <= cnt;
            freq_err   <= err_next;
            if (win_good) begin
              miss_cnt <= '0;
            end else if (miss_cnt == MW'(MISS_CNT - 1)) begin
              state    <= ACQ;
              lock     <= 1'b0;
              good_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + MW'(1);
            end
          end
          default: begin
            state <= IDLE;
            lock  <= 1'b0;
          end
        endcase
      end else if (state == IDLE && cnt_sat) begin
        ref_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Scoreboard bench for adpll_lock_monitor: a period-level model predicts each window result.
module tb_adpll_lock_monitor;

  localparam int unsigned CW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          ref_in;
  logic          M2, M1, M0;
  logic          lock;
  logic          meas_valid;
  logic [CW-1:0] meas_count;
  logic [CW:0]   freq_err;
  logic          ref_lost;

  adpll_lock_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .ref_in     (ref_in),
    .M2         (M2),
    .M1         (M1),
    .M0         (M0),
    .lock       (lock),
    .meas_valid (meas_valid),
    .meas_count (meas_count),
    .freq_err   (freq_err),
    .ref_lost   (ref_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int count;
    int err;
    bit lk;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  bit armed;
  bit m_locked;
  int gc;
  int mc;
  int last_edge;
  int cur_m;

  function automatic int tgt(input int m);
    return 8 * (m + 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Period-level reference: every REF edge closes the window opened by the previous one
  task automatic model_edge();
    int  len;
    int  err;
    bit  good;
    if (armed) begin
      len = cyc - last_edge;
      if (len >= 4000) begin
        m_locked = 1'b0;
        gc = 0;
        mc = 0;
      end else begin
        err  = len - tgt(cur_m);
        good = (err <= 1) && (err >= -1);
        if (!m_locked) begin
          if (good) begin
            gc++;
            if (gc == 4) begin
              m_locked = 1'b1;
              gc = 0;
              mc = 0;
            end
          end else begin
            gc = 0;
          end
        end else begin
          if (good) begin
            mc = 0;
          end else begin
            mc++;
            if (mc == 2) begin
              m_locked = 1'b0;
              gc = 0;
              mc = 0;
            end
          end
        end
        check("sb_drained_before_push", sbq.size(), 0);
        sbq.push_back('{count: len, err: err, lk: m_locked});
      end
    end
    armed     = 1'b1;
    last_edge = cyc;
  endtask

  task automatic send_edge(input int p);
    ref_in = 1'b1;
    model_edge();
    repeat (p / 2) @(negedge clk);
    ref_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic set_m(input int v);
    if (v != cur_m) begin
      {M2, M1, M0} = 3'(v);
      cur_m    = v;
      armed    = 1'b0;
      m_locked = 1'b0;
      gc = 0;
      mc = 0;
      @(negedge clk);
      check("lock_after_ratio_change", int'(lock), 0);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_lock", int'(lock), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_meas_count", int'(meas_count), 0);
    check("rst_freq_err", int'(freq_err), 0);
    check("rst_ref_lost", int'(ref_lost), 0);
    check("sb_drained_at_reset", sbq.size(), 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    armed    = 1'b0;
    m_locked = 1'b0;
    gc = 0;
    mc = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   r;
    int   p;
    reset  = 1'b1;
    ref_in = 1'b0;
    {M2, M1, M0} = 3'd3;
    cur_m    = 3;
    armed    = 1'b0;
    m_locked = 1'b0;
    gc = 0;
    mc = 0;
    last_edge = 0;

    // Monitor: compare every meas_valid pulse against the oldest prediction
    fork
      forever begin
        @(negedge clk);
        if (!reset && meas_valid) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_meas_valid: got pulse with count %0d, expected none (t=%0t)",
                     meas_count, $time);
          end else begin
            e = sbq.pop_front();
            check("meas_count", int'(meas_count), e.count);
            check("freq_err", int'($signed(freq_err)), e.err);
            check("lock_at_meas", int'(lock), int'(e.lk));
            check("ref_lost_at_meas", int'(ref_lost), 0);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    do_reset();

    // Acquire at M=3
    repeat (6) send_edge(32);
    check("t1_lock", int'(lock), 1);

    // Two slow windows drop lock, in-tolerance windows reacquire
    send_edge(34);
    send_edge(34);
    send_edge(33);
    check("t2_lock_dropped", int'(lock), 0);
    repeat (4) send_edge(33);
    check("t2_relock", int'(lock), 1);

    // Single bad window is forgiven
    send_edge(30);
    send_edge(32);
    send_edge(32);
    check("t3_lock_held", int'(lock), 1);

    // Reference loss and recovery
    repeat (4300) @(negedge clk);
    check("t4_lock_lost", int'(lock), 0);
    check("t4_ref_lost", int'(ref_lost), 1);
    send_edge(32);
    check("t4_ref_lost_cleared", int'(ref_lost), 0);
    repeat (5) send_edge(32);
    check("t4_relock", int'(lock), 1);

    // Ratio change mid-window
    set_m(7);
    repeat (5) send_edge(64);
    check("t5_lock_m7", int'(lock), 1);

    // Reset while locked, then an opening-only edge
    do_reset();
    send_edge(64);

    // Randomized windows around the target with occasional ratio changes and resets
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        set_m(int'($urandom_range(0, 7)));
      end else if (r < 11) begin
        do_reset();
      end
      if (int'($urandom_range(0, 99)) < 70) begin
        p = tgt(cur_m) + int'($urandom_range(0, 2)) - 1;
      end else begin
        p = tgt(cur_m) + int'($urandom_range(0, 8)) - 4;
      end
      if (p < 8) p = 8;
      send_edge(p);
    end

    repeat (10) @(negedge clk);
    check("sb_empty_at_end", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
